// File: rtl/jtvigil_pcm_pkg.sv
// Shared constants for the Vigilante PCM sample fetcher: I/O port map,
// FSM state encoding and the DAC offset-binary conversion.
package jtvigil_pcm_pkg;

  localparam logic [2:0] PORT_ADDR_LO = 3'd0;
  localparam logic [2:0] PORT_ADDR_HI = 3'd1;
  localparam logic [2:0] PORT_DAC     = 3'd2;
  localparam logic [2:0] PORT_INC     = 3'd3;
  localparam logic [2:0] PORT_DATA    = 3'd4;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_FETCH = 2'd1;
  localparam logic [1:0] STATE_VALID = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_FETCH = STATE_FETCH,
    ST_VALID = STATE_VALID
  } state_t;

  localparam logic [7:0]  DAC_RESET  = 8'h80;
  localparam logic [7:0]  READ_FLOAT = 8'hFF;
  localparam logic [15:0] ADDR_RESET = 16'h0000;

  // The DAC register holds offset binary; the output is two's complement.
  function automatic logic [7:0] dac_to_signed(input logic [7:0] v);
    return {~v[7], v[6:0]};
  endfunction

endpackage

// File: rtl/jtvigil_pcm.sv
// PCM sample fetcher and 8-bit DAC for the Vigilante sound CPU.
// Define JTVIGIL_PCM_AUTOINC_EN to make each completed data read advance the address.
module jtvigil_pcm
  import jtvigil_pcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [2:0]        port,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              wait_n,
  output logic [15:0]       rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic signed [7:0] snd,
  output logic              sample
);

  state_t      state_q, state_d;
  logic        age_q, age_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dbuf_q, dbuf_d;
  logic [7:0]  dac_q, dac_d;
  logic        rom_cs_q, rom_cs_d;
  logic        sample_q, sample_d;
  logic        rd_data_s;
  logic        wr_s;
  logic        trig_s;

  assign rom_addr = addr_q;
  assign rom_cs   = rom_cs_q;
  assign sample   = sample_q;
  assign snd      = dac_to_signed(dac_q);

  // CPU read path: data reads stall only while a fetch is outstanding
  always_comb begin
    rd_data_s = io_rd && (port == PORT_DATA);
    wait_n    = ~(rd_data_s && (state_q == ST_FETCH));
    if (rd_data_s) begin
      cpu_dout = dbuf_q;
    end else begin
      cpu_dout = READ_FLOAT;
    end
  end

  // Address register, DAC register and fetch trigger from CPU port accesses
  always_comb begin
    wr_s     = io_wr && cen;
    addr_d   = addr_q;
    trig_s   = 1'b0;
    dac_d    = dac_q;
    sample_d = 1'b0;
    if (wr_s) begin
      case (port)
        PORT_ADDR_LO: begin
          addr_d = {addr_q[15:8], cpu_din};
          trig_s = 1'b1;
        end
        PORT_ADDR_HI: begin
          addr_d = {cpu_din, addr_q[7:0]};
          trig_s = 1'b1;
        end
        PORT_INC: begin
          addr_d = addr_q + 16'd1;
          trig_s = 1'b1;
        end
        PORT_DAC: begin
          dac_d    = cpu_din;
          sample_d = 1'b1;
        end
        default: begin
          addr_d = addr_q;
        end
      endcase
    end else begin
`ifdef JTVIGIL_PCM_AUTOINC_EN
      // a read completes on the cycle it is not stalled; the next fetch follows it
      if (cen && rd_data_s && wait_n) begin
        addr_d = addr_q + 16'd1;
        trig_s = 1'b1;
      end else begin
        addr_d = addr_q;
      end
`else
      addr_d = addr_q;
`endif
    end
  end

  // Fetch FSM: a trigger always restarts, and rom_ok is trusted only once age is set
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    dbuf_d  = dbuf_q;
    if (trig_s) begin
      state_d = ST_FETCH;
      age_d   = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (age_q && rom_ok) begin
            dbuf_d  = rom_data;
            state_d = ST_VALID;
          end else begin
            age_d = 1'b1;
          end
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_VALID: state_d = ST_VALID;
        default:  state_d = ST_IDLE;
      endcase
    end
    rom_cs_d = (state_d == ST_FETCH);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      age_q    <= 1'b0;
      addr_q   <= ADDR_RESET;
      dbuf_q   <= 8'h00;
      dac_q    <= DAC_RESET;
      rom_cs_q <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      age_q    <= age_d;
      addr_q   <= addr_d;
      dbuf_q   <= dbuf_d;
      dac_q    <= dac_d;
      rom_cs_q <= rom_cs_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_jtvigil_pcm.sv
// Directed self-checking bench for jtvigil_pcm; the auto-increment scenario
// runs only when JTVIGIL_PCM_AUTOINC_EN is defined.
module tb_jtvigil_pcm;

  logic              clk = 1'b0;
  logic              rst, cen, io_wr, io_rd, rom_cs, rom_ok, wait_n, sample;
  logic [2:0]        port;
  logic [7:0]        cpu_din, cpu_dout, rom_data;
  logic [15:0]       rom_addr;
  logic signed [7:0] snd;
  int                n_checks = 0;
  int                n_fail   = 0;

  jtvigil_pcm dut (
    .clk(clk), .rst(rst), .cen(cen), .port(port), .io_wr(io_wr), .io_rd(io_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .wait_n(wait_n),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .snd(snd), .sample(sample)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] p, input logic [7:0] d);
    port = p; cpu_din = d; io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; io_wr = 1'b0; io_rd = 1'b0; port = 3'd0;
    cpu_din = 8'h00; rom_ok = 1'b0; rom_data = 8'h00;
    tick(); tick();
    n_checks++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", rom_addr); end
    n_checks++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", rom_cs); end
    n_checks++; if (wait_n !== 1'b1 || sample !== 1'b0) begin n_fail++; $display("FAIL reset_wait_sample: got %b%b want 10", wait_n, sample); end
    n_checks++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout: got %h want ff", cpu_dout); end
    n_checks++; if (snd !== 8'sd0) begin n_fail++; $display("FAIL reset_snd: got %0d want 0", snd); end
    rst = 1'b0;
    tick();
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'h00 || wait_n !== 1'b1) begin n_fail++; $display("FAIL idle_read: got %h/%b want 00/1", cpu_dout, wait_n); end
    tick(); io_rd = 1'b0;
  endtask

  task automatic test_fetch();
    cpu_write(3'd0, 8'h34);
    n_checks++; if (rom_addr !== 16'h0034 || rom_cs !== 1'b1) begin n_fail++; $display("FAIL fetch_lo: got %h/%b want 0034/1", rom_addr, rom_cs); end
    cpu_write(3'd1, 8'h12);
    n_checks++; if (rom_addr !== 16'h1234) begin n_fail++; $display("FAIL fetch_addr: got %h want 1234", rom_addr); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rom_cs !== 1'b1) begin n_fail++; $display("FAIL fetch_cs_%0d: got %b want 1", i, rom_cs); end
      if (i == 2) begin rom_data = 8'h5C; rom_ok = 1'b1; end
      tick();
    end
    rom_ok = 1'b0;
    n_checks++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_cs: got %b want 0", rom_cs); end
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'h5C || wait_n !== 1'b1) begin n_fail++; $display("FAIL fetch_read: got %h/%b want 5c/1", cpu_dout, wait_n); end
    tick(); io_rd = 1'b0;
    n_checks++; if (rom_addr !== 16'h1234 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL read_no_inc: got %h/%b want 1234/0", rom_addr, rom_cs); end
  endtask

  task automatic test_stale_ok();
    rom_data = 8'hAA; rom_ok = 1'b1;
    cpu_write(3'd0, 8'h56);
    n_checks++; if (rom_cs !== 1'b1) begin n_fail++; $display("FAIL stale_first: got %b want 1", rom_cs); end
    tick();
    n_checks++; if (rom_cs !== 1'b1) begin n_fail++; $display("FAIL stale_ignored: got %b want 1", rom_cs); end
    tick();
    n_checks++; if (rom_cs !== 1'b0) begin n_fail++; $display("FAIL stale_latched_cs: got %b want 0", rom_cs); end
    rom_ok = 1'b0;
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'hAA) begin n_fail++; $display("FAIL stale_data: got %h want aa", cpu_dout); end
    tick(); io_rd = 1'b0;
  endtask

  task automatic test_wrap();
    cpu_write(3'd0, 8'hFF);
    cpu_write(3'd1, 8'hFF);
    n_checks++; if (rom_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want ffff", rom_addr); end
    cpu_write(3'd3, 8'h00);
    n_checks++; if (rom_addr !== 16'h0000 || rom_cs !== 1'b1) begin n_fail++; $display("FAIL wrap: got %h/%b want 0000/1", rom_addr, rom_cs); end
    rom_data = 8'h11; rom_ok = 1'b1;
    tick(); tick();
    rom_ok = 1'b0;
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'h11 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL wrap_data: got %h/%b want 11/0", cpu_dout, rom_cs); end
    tick(); io_rd = 1'b0;
    cpu_write(3'd3, 8'h00);
    n_checks++; if (rom_addr !== 16'h0001) begin n_fail++; $display("FAIL inc: got %h want 0001", rom_addr); end
  endtask

  task automatic test_wait();
    int stalls = 0;
    cpu_write(3'd0, 8'h40);
    port = 3'd4; io_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (wait_n === 1'b0) stalls++;
      if (i == 9) begin rom_data = 8'h77; rom_ok = 1'b1; end
      tick();
    end
    rom_ok = 1'b0;
    n_checks++; if (stalls !== 10) begin n_fail++; $display("FAIL wait_count: got %0d want 10", stalls); end
    #1;
    n_checks++; if (wait_n !== 1'b1 || cpu_dout !== 8'h77) begin n_fail++; $display("FAIL wait_done: got %b/%h want 1/77", wait_n, cpu_dout); end
    tick(); io_rd = 1'b0;
  endtask

  task automatic test_restart();
    cpu_write(3'd0, 8'h00);
    tick();
    rom_data = 8'hEE; rom_ok = 1'b1;
    cpu_write(3'd1, 8'h21);
    tick();
    rom_ok = 1'b0;
    n_checks++; if (rom_cs !== 1'b1 || rom_addr !== 16'h2100) begin n_fail++; $display("FAIL restart_pending: got %b/%h want 1/2100", rom_cs, rom_addr); end
    rom_data = 8'h21; rom_ok = 1'b1;
    tick();
    rom_ok = 1'b0;
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'h21 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL restart_data: got %h/%b want 21/0", cpu_dout, rom_cs); end
    tick(); io_rd = 1'b0;
  endtask

  task automatic test_dac();
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("FAIL dac_idle: got %b want 0", sample); end
    cpu_write(3'd2, 8'h00);
    n_checks++; if (snd !== -8'sd128 || sample !== 1'b1) begin n_fail++; $display("FAIL dac_00: got %0d/%b want -128/1", snd, sample); end
    tick();
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("FAIL dac_pulse0: got %b want 0", sample); end
    cpu_write(3'd2, 8'hFF);
    n_checks++; if (snd !== 8'sd127 || sample !== 1'b1) begin n_fail++; $display("FAIL dac_ff: got %0d/%b want 127/1", snd, sample); end
    tick();
    n_checks++; if (sample !== 1'b0 || snd !== 8'sd127) begin n_fail++; $display("FAIL dac_pulse1: got %b/%0d want 0/127", sample, snd); end
  endtask

  task automatic test_other_reads();
    logic [2:0] plist [7];
    plist = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    io_rd = 1'b1;
    for (int i = 0; i < 7; i++) begin
      port = plist[i]; #1;
      n_checks++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL other_read_p%0d: got %h want ff", plist[i], cpu_dout); end
    end
    tick(); io_rd = 1'b0;
  endtask

  task automatic test_cen();
    cen = 1'b0;
    cpu_write(3'd0, 8'h99);
    n_checks++; if (rom_addr !== 16'h2100 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL cen_addr: got %h/%b want 2100/0", rom_addr, rom_cs); end
    cpu_write(3'd2, 8'h10);
    n_checks++; if (sample !== 1'b0 || snd !== 8'sd127) begin n_fail++; $display("FAIL cen_dac: got %b/%0d want 0/127", sample, snd); end
    cen = 1'b1;
  endtask

`ifdef JTVIGIL_PCM_AUTOINC_EN
  task automatic test_autoinc();
    rom_data = 8'h3C; rom_ok = 1'b1;
    cpu_write(3'd0, 8'h10);
    cpu_write(3'd1, 8'h00);
    tick(); tick();
    for (int r = 0; r < 2; r++) begin
      port = 3'd4; io_rd = 1'b1;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (wait_n === 1'b1) break;
        tick();
      end
      n_checks++; if (wait_n !== 1'b1) begin n_fail++; $display("FAIL autoinc_wait_%0d: timeout, wait_n %b", r, wait_n); end
      tick(); io_rd = 1'b0;
    end
    n_checks++; if (rom_addr !== 16'h0012) begin n_fail++; $display("FAIL autoinc_addr: got %h want 0012", rom_addr); end
    tick(); tick();
    rom_ok = 1'b0;
  endtask
`endif

  task automatic test_reset_abort();
    cpu_write(3'd0, 8'h42);
    rst = 1'b1; #1;
    n_checks++; if (rom_cs !== 1'b0 || rom_addr !== 16'h0000) begin n_fail++; $display("FAIL abort_cs: got %b/%h want 0/0000", rom_cs, rom_addr); end
    rom_data = 8'hBB; rom_ok = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    port = 3'd4; io_rd = 1'b1; #1;
    n_checks++; if (cpu_dout !== 8'h00 || rom_cs !== 1'b0) begin n_fail++; $display("FAIL abort_dbuf: got %h/%b want 00/0", cpu_dout, rom_cs); end
    tick(); io_rd = 1'b0; rom_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stale_ok();
    test_wrap();
    test_wait();
    test_restart();
    test_dac();
    test_other_reads();
    test_cen();
`ifdef JTVIGIL_PCM_AUTOINC_EN
    test_autoinc();
`endif
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtvigil_pcm.md
JTVIGIL_PCM -- requirements
Module: jtvigil_pcm

Interface
REQ-001 SHALL have ports clk (in, 1, system clock, sole clock) and rst (in, 1); reset is asynchronous and active-high.
REQ-002 SHALL have cen (in, 1): sound CPU clock enable; CPU-side register updates happen only on cycles with cen=1.
REQ-003 SHALL have port (in, 3): sound CPU I/O port select (0 addr low, 1 addr high, 2 DAC, 3 increment, 4 data read).
REQ-004 SHALL have io_wr (in, 1) and io_rd (in, 1): I/O write/read strobes; at most one is high per cycle.
REQ-005 SHALL have cpu_din (in, 8), the CPU write data, and cpu_dout (out, 8), the CPU read data.
REQ-006 SHALL have wait_n (out, 1): low stalls the sound CPU.
REQ-007 SHALL have rom_addr (out, 16), rom_cs (out, 1), rom_data (in, 8) and rom_ok (in, 1), forming the PCM ROM port of the SDRAM controller.
REQ-008 SHALL have snd (out, signed 8): DAC output.
REQ-009 SHALL have sample (out, 1): one-clk pulse on each DAC write.

Function
REQ-010 Port 0 write SHALL load addr[7:0] and port 1 write SHALL load addr[15:8]; both SHALL trigger a new fetch.
REQ-011 Port 3 write SHALL increment addr by 1 modulo 2^16 (FFFF wraps to 0000) and SHALL trigger a new fetch.
REQ-012 The FSM SHALL have three states:
- IDLE: nothing pending.
- FETCH: rom_cs=1.
- VALID: data latched, rom_cs=0.
REQ-013 A fetch trigger SHALL enter FETCH from any state and clear the fetch-age counter.
REQ-014 In FETCH, rom_ok SHALL be ignored for the first clk after entry (stale ok). The first rom_ok=1 from the second clk on SHALL latch rom_data into dbuf and go to VALID.
REQ-015 A fetch trigger arriving while in FETCH SHALL restart the fetch at the new addr; the old data SHALL never reach dbuf.
REQ-016 A port 4 read in VALID SHALL give cpu_dout=dbuf in the same cycle, with wait_n=1.
REQ-017 A port 4 read in FETCH SHALL drive wait_n=0 combinationally until VALID is reached; the read then completes with the new dbuf.
REQ-018 A port 4 read in IDLE SHALL return dbuf, with wait_n=1.
REQ-019 Reads of ports other than 4 SHALL return FF.
REQ-020 Port 2 write SHALL load the DAC register. On the next clk, snd SHALL equal {~din[7], din[6:0]} and sample SHALL pulse high for 1 clk.
REQ-021 rom_addr SHALL always equal addr.

Reset
REQ-022 Reset SHALL force:
- addr=0, dbuf=0, DAC=80 (snd=0);
- state IDLE, rom_cs=0;
- wait_n=1, sample=0, cpu_dout=FF.
REQ-023 Reset asserted during FETCH SHALL abort the fetch immediately; no rom_ok arriving afterwards SHALL alter dbuf.

Configuration
REQ-024 With JTVIGIL_PCM_AUTOINC_EN defined, each completed port 4 read SHALL increment addr (wrapping) and trigger a fetch in the cycle after data is returned.
REQ-025 Without JTVIGIL_PCM_AUTOINC_EN, port 4 reads SHALL NOT change addr; only writes to ports 0, 1 and 3 trigger fetches.

Structure
REQ-026 Port numbers and the state encoding SHALL be localparams in a shared package, jtvigil_pcm_pkg.
REQ-027 The block SHALL be a single module with no sub-modules. It is instantiated in jtvigil_snd, with the ROM port wired to pcm_addr/pcm_cs/pcm_data/pcm_ok.

Verification
REQ-028 Write port0=34, then port1=12, with rom_ok returned 3 clk after cs -> rom_addr=1234, rom_cs high until ok, then state VALID; a port 4 read returns rom_data.
REQ-029 rom_ok held high from the cycle a fetch is triggered, with ROM model data=AA -> ok ignored for 1 clk, dbuf=AA latched on the 2nd clk.
REQ-030 addr=FFFF, then port 3 write -> addr=0000 and a new fetch is issued.
REQ-031 Port 4 read while FETCH is pending for 10 clk -> wait_n low for those 10 clk, then cpu_dout=new data with wait_n high.
REQ-032 Port1 write mid-fetch, then rom_ok for the old address -> old data discarded, fetch restarts at the new addr.
REQ-033 Port 2 write of 00, then FF -> snd=-128 then +127, each followed by a 1-clk sample pulse; with AUTOINC, two port 4 reads from addr 0010 -> addr=0012.
